audio_gain_sched: RTL
=====================

AUDIO_GAIN_SCHED -- requirements
Module: audio_gain_sched

Parameters
REQ-001 The block SHALL have parameter GAIN_W, default 12, meaning gain word width; unity gain is 2^(GAIN_W-1) = 2048.
REQ-002 The block SHALL have parameter RAMP_STEP, default 64, meaning the maximum change of effective gain per frame.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port valid, input, 1 bit, the sample-pair-ready level from the codec interface; only its rising edge is used.
REQ-006 The block SHALL have ports lft_in and rht_in, input, 16 bits each, signed two's-complement samples.
REQ-007 The block SHALL have port vol, input, GAIN_W bits, unsigned target gain.
REQ-008 The block SHALL have port mute, input, 1 bit; when high the target gain is 0.
REQ-009 The block SHALL have port ovr_clr, input, 1 bit, which clears overrun.
REQ-010 The block SHALL have ports lft_out and rht_out, output, 16 bits each, registered signed scaled samples.
REQ-011 The block SHALL have port out_vld, output, 1 bit, a one-cycle pulse when lft_out/rht_out update.
REQ-012 The block SHALL have port busy, output, 1 bit, high whenever state != IDLE.
REQ-013 The block SHALL have port overrun, output, 1 bit, a sticky flag for a frame dropped while busy.

Function
REQ-014 The FSM SHALL have states IDLE, MUL_L, MUL_R and UPD: IDLE->MUL_L on a valid edge; MUL_L->MUL_R, MUL_R->UPD and UPD->IDLE unconditionally.
REQ-015 A valid edge SHALL be defined as valid=1 and valid_d=0, where valid_d is valid registered by one clock.
REQ-016 On a valid edge in IDLE, the block SHALL capture lft_in/rht_in into internal registers and update g_eff in the same clock.
REQ-017 The g_eff ramp SHALL proceed as follows: target = mute ? 0 : vol; if |target - g_eff| <= RAMP_STEP then g_eff = target, else g_eff moves RAMP_STEP toward target; g_eff changes only at frame capture.
REQ-018 A single shared signed multiplier SHALL be used: MUL_L computes the left sample times {0,g_eff} and MUL_R computes the right sample times {0,g_eff}, each into a registered 29-bit product.
REQ-019 Scaling SHALL be product arithmetic-shifted right by GAIN_W-1 (floor), then saturated to [-32768, 32767].
REQ-020 In UPD, lft_out and rht_out SHALL load the scaled values and out_vld SHALL be high in the following cycle only.
REQ-021 Latency SHALL be exactly 4 clocks: for an edge sampled in cycle E, out_vld=1 and the new outputs are visible in cycle E+4.
REQ-022 lft_out and rht_out SHALL hold their values between updates.
REQ-023 A valid edge while state != IDLE SHALL be dropped (no capture, no g_eff change) and SHALL set overrun.
REQ-024 overrun SHALL clear on ovr_clr=1; when set and clear occur in the same cycle, set wins.
REQ-025 A valid held high continuously SHALL produce only one frame.
REQ-026 Changes to vol or mute mid-frame SHALL not affect the frame in progress.

Reset
REQ-027 On rst=1 at a clock edge, the block SHALL set state=IDLE, lft_out=0, rht_out=0, out_vld=0, busy=0, overrun=0, g_eff=0, internal sample and product registers=0, and valid_d=1.
REQ-028 Because valid_d resets to 1, a valid held high through reset SHALL not create an edge.
REQ-029 rst asserted mid-frame SHALL abort the frame with no out_vld pulse; rst has priority over all other inputs.

Verification
REQ-030 Unity scenario: RAMP_STEP=4095, vol=2048, lft_in=0x1000, rht_in=0xF000, valid edge at E -> out_vld at E+4 only, lft_out=0x1000, rht_out=0xF000, busy high E+1..E+3.
REQ-031 Saturation scenario: RAMP_STEP=4095, vol=4095, lft_in=0x7FFF, rht_in=0x8000 -> lft_out=0x7FFF, rht_out=0x8000; lft_in=0xFFFF with vol=1024 -> 0xFFFF (floor).
REQ-032 Ramp scenario: defaults, vol=2048, lft_in=0x4000 every frame -> frame 1 lft_out=0x0200, frame 2 lft_out=0x0400, frame 32 and after lft_out=0x4000; then mute=1 -> frame 32 after mute gives lft_out=0x0000.
REQ-033 Overrun scenario: a second valid edge at E+2 -> no second capture, overrun=1 from E+3, outputs reflect first frame only; ovr_clr pulse -> overrun=0; ovr_clr coinciding with a new drop -> overrun stays 1.
REQ-034 Reset scenario: rst pulse during MUL_R -> next cycle busy=0, outputs=0, no out_vld; valid held high across reset -> no frame until valid falls and rises again.

Source files
------------

// File: rtl/audio_gain_sched.sv
// Stereo gain stage: per-frame gain ramp, one shared multiplier.
// Four-state schedule from frame capture to registered, saturated output.
module audio_gain_sched #(
  parameter int GAIN_W    = 12,
  parameter int RAMP_STEP = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [15:0]       lft_in,
  input  logic [15:0]       rht_in,
  input  logic [GAIN_W-1:0] vol,
  input  logic              mute,
  input  logic              ovr_clr,
  output logic [15:0]       lft_out,
  output logic [15:0]       rht_out,
  output logic              out_vld,
  output logic              busy,
  output logic              overrun
);

  localparam int PW = 16 + GAIN_W + 1;
  localparam int DW = GAIN_W + 2;
  localparam logic signed [PW-1:0] SMAX = PW'(32767);
  localparam logic signed [PW-1:0] SMIN = PW'(-32768);

  typedef enum logic [1:0] {
    IDLE,
    MUL_L,
    MUL_R,
    UPD
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_valid_d;
  logic                     w_edge;
  logic signed [15:0]       r_lft;
  logic signed [15:0]       r_rht;
  logic        [GAIN_W-1:0] r_geff;
  logic        [GAIN_W-1:0] w_target;
  logic        [GAIN_W-1:0] w_gnext;
  logic signed [DW-1:0]     w_diff;
  logic signed [DW-1:0]     w_abs;
  logic signed [DW-1:0]     w_step;
  logic signed [15:0]       w_mul_a;
  logic signed [PW-1:0]     w_prod;
  logic signed [PW-1:0]     r_prod_l;
  logic signed [PW-1:0]     r_prod_r;
  logic        [15:0]       r_lo;
  logic        [15:0]       r_ro;
  logic                     r_vld;
  logic                     r_ovr;

  function automatic logic [15:0] scale(
    input logic signed [PW-1:0] p
  );
    logic signed [PW-1:0] s;
    s = p >>> (GAIN_W - 1);
    if (s > SMAX)
      return 16'h7fff;
    else if (s < SMIN)
      return 16'h8000;
    else
      return s[15:0];
  endfunction

  assign w_edge = valid & ~r_valid_d;
  assign w_target = mute ? '0 : vol;
  assign w_step = DW'(RAMP_STEP);
  assign w_diff = $signed({2'b00, w_target})
                - $signed({2'b00, r_geff});
  assign w_abs = w_diff[DW-1] ? -w_diff : w_diff;

  always_comb begin
    w_gnext = w_target;
    if (w_abs > w_step) begin
      if (w_diff[DW-1])
        w_gnext = r_geff - GAIN_W'(RAMP_STEP);
      else
        w_gnext = r_geff + GAIN_W'(RAMP_STEP);
    end
  end

  // One multiplier, operand steered by schedule state
  assign w_mul_a = (r_state == MUL_R) ? r_rht : r_lft;
  assign w_prod = PW'(w_mul_a)
                * PW'($signed({1'b0, r_geff}));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_edge) w_next = MUL_L;
      MUL_L:   w_next = MUL_R;
      MUL_R:   w_next = UPD;
      UPD:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_valid_d <= 1'b1;
      r_lft     <= '0;
      r_rht     <= '0;
      r_geff    <= '0;
      r_prod_l  <= '0;
      r_prod_r  <= '0;
      r_lo      <= '0;
      r_ro      <= '0;
      r_vld     <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_valid_d <= valid;
      r_vld     <= 1'b0;
      if (r_state == IDLE && w_edge) begin
        r_lft  <= lft_in;
        r_rht  <= rht_in;
        r_geff <= w_gnext;
      end
      if (r_state == MUL_L)
        r_prod_l <= w_prod;
      if (r_state == MUL_R)
        r_prod_r <= w_prod;
      if (r_state == UPD) begin
        r_lo  <= scale(r_prod_l);
        r_ro  <= scale(r_prod_r);
        r_vld <= 1'b1;
      end
      // A drop in the same cycle as a clear keeps the flag
      if (w_edge && r_state != IDLE)
        r_ovr <= 1'b1;
      else if (ovr_clr)
        r_ovr <= 1'b0;
    end
  end

  assign lft_out = r_lo;
  assign rht_out = r_ro;
  assign out_vld = r_vld;
  assign overrun = r_ovr;
  assign busy    = (r_state != IDLE);

endmodule
